y86_mem_target: RTL

Bus responder that services the y86 sequential core's memory bus: it answers instruction/data reads from a byte-addressed little-endian array and absorbs stores into a small posted-write queue that drains into the array when the read port is idle. It sits between the core's bus master pins and the backing store, with a byte-wide loader port for the bench to preload programs before the core leaves reset.

---
 rtl/y86_mem_pkg.sv | 19 +
 rtl/y86_mem_if.sv | 12 +
 rtl/y86_wbuf.sv | 68 ++++++
 rtl/y86_mem_target.sv | 109 ++++++++++
 4 files changed

// File: rtl/y86_mem_pkg.sv
// Shared types and constants for the y86 memory target: write-queue entry
// layout, byte-lane helpers and default geometry.
package y86_mem_pkg;

  localparam int DEF_DEPTH_BYTES = 4096;
  localparam int DEF_WBUF_DEPTH  = 2;
  localparam int BYTE_W          = 8;
  localparam int WORD_BYTES      = 4;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wbuf_entry_t;

  function automatic logic [7:0] lane_byte(input logic [31:0] word, input logic [1:0] lane);
    return word[{lane, 3'b000} +: BYTE_W];
  endfunction

endpackage

// File: rtl/y86_mem_if.sv
// Core-side memory bus of the y86 sequential core: the core is the master,
// the memory target is the slave.
interface y86_mem_if;
  logic [31:0] bus_A;
  logic        bus_RE;
  logic        bus_WE;
  logic [31:0] bus_out;
  logic [31:0] bus_in;

  modport master (output bus_A, output bus_RE, output bus_WE, output bus_out, input bus_in);
  modport slave  (input bus_A, input bus_RE, input bus_WE, input bus_out, output bus_in);
endinterface

// File: rtl/y86_wbuf.sv
// Posted-write queue kept as a shift register: slot 0 is always the oldest
// entry, so forwarding logic can resolve age purely by slot index.
module y86_wbuf
  import y86_mem_pkg::*;
#(
  parameter int DEPTH = DEF_WBUF_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  wbuf_entry_t       push_entry,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output wbuf_entry_t       entries [DEPTH],
  output logic [DEPTH-1:0]  valid
);

  localparam int SW = $clog2(DEPTH);

  wbuf_entry_t      ent_q [DEPTH];
  wbuf_entry_t      ent_n [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [DEPTH-1:0] vld_n;
  logic [SW-1:0]    slot;
  logic             do_pop;
  logic             do_push;

  assign empty   = ~vld_q[0];
  assign full    = vld_q[DEPTH-1];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Pop shifts everything toward slot 0; push lands in the lowest free slot
  // after that shift, which keeps valid a thermometer code.
  always_comb begin
    ent_n = ent_q;
    vld_n = vld_q;
    slot  = '0;
    if (do_pop) begin
      for (int i = 0; i < DEPTH-1; i++) begin
        ent_n[i] = ent_q[i+1];
        vld_n[i] = vld_q[i+1];
      end
      vld_n[DEPTH-1] = 1'b0;
    end
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (!vld_n[i]) slot = SW'(i);
    end
    if (do_push) begin
      ent_n[slot] = push_entry;
      vld_n[slot] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) vld_q <= '0;
    else      vld_q <= vld_n;
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_n[i];
  end

  assign entries = ent_q;
  assign valid   = vld_q;

endmodule

// File: rtl/y86_mem_target.sv
// Memory responder for the y86 sequential core: combinational reads with
// store forwarding, posted writes drained on idle cycles, byte loader.
// Optional counters enabled by defining Y86_MEM_STATS_EN.
module y86_mem_target
  import y86_mem_pkg::*;
#(
  parameter int DEPTH_BYTES = DEF_DEPTH_BYTES,
  parameter int WBUF_DEPTH  = DEF_WBUF_DEPTH
) (
  input  logic        clk,
  input  logic        rst,
  y86_mem_if.slave    bus,
  input  logic        ld_en,
  input  logic [31:0] ld_addr,
  input  logic [7:0]  ld_data,
  output logic        busy,
  output logic        err,
  output logic [31:0] rd_count,
  output logic [31:0] wr_count
);

  localparam int AW = $clog2(DEPTH_BYTES);

  logic [7:0]            mem [DEPTH_BYTES];
  wbuf_entry_t           q_ent [WBUF_DEPTH];
  logic [WBUF_DEPTH-1:0] q_vld;
  logic                  q_full;
  logic                  q_empty;
  logic                  drain;
  logic                  accept;
  logic [31:0]           rd_word;
  logic [AW-1:0]         ba;
  logic [AW-1:0]         off;
  logic [7:0]            b;
  logic                  unused_addr;

  // The single array port goes to the loader first, then to drain, and only
  // when the core is not reading; drain is held off during reset so a
  // discarded entry never reaches the array.
  assign drain  = rst & ~bus.bus_RE & ~ld_en & ~q_empty;
  assign accept = bus.bus_WE & (~q_full | drain);
  assign busy   = ~q_empty;

  y86_wbuf #(.DEPTH(WBUF_DEPTH)) u_wbuf (
    .clk        (clk),
    .rst        (rst),
    .push       (bus.bus_WE),
    .push_entry ('{addr: bus.bus_A, data: bus.bus_out}),
    .pop        (drain),
    .full       (q_full),
    .empty      (q_empty),
    .entries    (q_ent),
    .valid      (q_vld)
  );

  // Higher slots are younger, so a later match overrides an earlier one.
  always_comb begin
    rd_word = '0;
    ba      = '0;
    off     = '0;
    b       = '0;
    for (int k = 0; k < WORD_BYTES; k++) begin
      ba = bus.bus_A[AW-1:0] + AW'(k);
      b  = mem[ba];
      for (int i = 0; i < WBUF_DEPTH; i++) begin
        off = ba - q_ent[i].addr[AW-1:0];
        if (q_vld[i] && off < AW'(WORD_BYTES)) b = lane_byte(q_ent[i].data, off[1:0]);
      end
      rd_word[k*BYTE_W +: BYTE_W] = b;
    end
  end

  assign bus.bus_in = bus.bus_RE ? rd_word : '0;

  always_ff @(posedge clk) begin
    if (ld_en) begin
      mem[ld_addr[AW-1:0]] <= ld_data;
    end else if (drain) begin
      for (int k = 0; k < WORD_BYTES; k++)
        mem[q_ent[0].addr[AW-1:0] + AW'(k)] <= lane_byte(q_ent[0].data, 2'(k));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst)                        err <= 1'b0;
    else if (bus.bus_WE && !accept)  err <= 1'b1;
  end

`ifdef Y86_MEM_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_count <= '0;
      wr_count <= '0;
    end else begin
      if (bus.bus_RE) rd_count <= rd_count + 32'd1;
      if (accept)     wr_count <= wr_count + 32'd1;
    end
  end
`else
  assign rd_count = '0;
  assign wr_count = '0;
`endif

  always_comb begin
    unused_addr = ^{bus.bus_A[31:AW], ld_addr[31:AW]};
    for (int i = 0; i < WBUF_DEPTH; i++) unused_addr = unused_addr ^ (^q_ent[i].addr[31:AW]);
  end

endmodule
